// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared constants for the registered N-way channel multiplexer.
//   - DEF_W / DEF_N : default data width and channel count
//   - MODE_DIRECT / MODE_RR : encoding of the mode input
//   - chan_w()      : channel-index width, never narrower than one bit
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int DEF_W = 32;
    localparam int DEF_N = 4;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
//   Combinational round-robin arbiter. Picks the first requesting channel
//   starting at (last + 1) mod N and wrapping around.
//   Ports:
//     req         [N]  in  : per-channel request
//     last        [SW] in  : most recently granted channel
//     grant       [SW] out : chosen channel (valid only with grant_valid)
//     grant_valid      out : at least one request is present
// ---------------------------------------------------------------------------
module rr_arb
    import mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = chan_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [SW-1:0] grant,
    output logic          grant_valid
);

    // Walk the offsets from farthest to nearest so that the nearest
    // requester after 'last' is the final (winning) assignment.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (req[idx[SW-1:0]]) begin
                grant       = idx[SW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg
//   N-channel valid/ready multiplexer with a single registered output stage.
//   Channel choice is either direct (sel) or round-robin (rr_arb).
//   Ports:
//     clk, rst_n         : rising-edge clock, synchronous active-low reset
//     in_data  [N*W]     : channel i at [i*W +: W]
//     in_valid [N]       : per-channel valid
//     in_ready [N]       : per-channel accept (combinational, one-hot or 0)
//     mode               : MODE_DIRECT / MODE_RR
//     sel      [SW]      : channel index used in direct mode
//     out_data [W]       : registered selected word
//     out_chan [SW]      : channel that supplied out_data
//     out_valid          : output register holds data
//     out_ready          : downstream accept
// ---------------------------------------------------------------------------
module mux_n_reg
    import mux_pkg::*;
#(
    parameter  int W  = DEF_W,
    parameter  int N  = DEF_N,
    localparam int SW = chan_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  chan_data [N];
    logic [SW-1:0] last;
    logic [SW-1:0] rr_grant;
    logic          rr_grant_valid;
    logic [SW-1:0] grant;
    logic          grant_valid;
    logic          load_ok;
    logic          take;

    logic [W-1:0]  data_p1;
    logic [SW-1:0] chan_p1;
    logic          vld_p1;

    for (genvar i = 0; i < N; i++) begin : g_split
        assign chan_data[i] = in_data[i*W +: W];
    end

    rr_arb #(
        .N  (N),
        .SW (SW)
    ) u_rr_arb (
        .req         (in_valid),
        .last        (last),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    // Direct mode ignores out-of-range indices; the range test also keeps
    // the in_valid lookup below from ever using an index past N-1.
    always_comb begin
        grant       = sel;
        grant_valid = 1'b0;
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_grant_valid;
        end else if (int'(sel) < N) begin
            grant_valid = in_valid[sel];
        end
    end

    assign load_ok = !vld_p1 || out_ready;

    // A grant always points at a valid channel, so granting while the
    // register can load is exactly an input transfer. Reset gates it off.
    assign take = rst_n && load_ok && grant_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = take && (grant == SW'(i));
        end
    end

    // Stage p0 -> p1: output register; a simultaneous in/out transfer
    // simply overwrites, giving one word per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            chan_p1 <= '0;
            last    <= SW'(N-1);
        end else if (take) begin
            vld_p1  <= 1'b1;
            data_p1 <= chan_data[grant];
            chan_p1 <= grant;
            last    <= grant;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_chan  = chan_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  chan;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic [1:0]   out_chan;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [31:0]  out_data3;
    logic [1:0]   out_chan3;
    logic         out_valid3;
    logic         out_ready3;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_n_reg #(.W(32), .N(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_n_reg #(.W(32), .N(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every output transfer pops one expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got data=%0h chan=%0d expected none", out_data, out_chan);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_data", out_data, e.data);
                check("sb_chan", 32'(out_chan), 32'(e.chan));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = {32'd4, 32'd3, 32'd2, 32'd1};
        in_valid   = '0;
        mode       = 1'b0;
        sel        = '0;
        out_ready  = 1'b0;
        in_data3   = {32'd30, 32'd20, 32'd10};
        in_valid3  = '0;
        mode3      = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b1;

        // Reset state; in_ready must stay low while reset is held
        step();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);
        in_valid = '0;
        rst_n    = 1'b1;

        // Direct select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        #1;
        check("dir_in_ready", 32'(in_ready), 32'h4);
        exp_q.push_back('{data: 32'd3, chan: 2'd2});
        step();
        in_valid = '0;
        #1;
        check("dir_out_valid", 32'(out_valid), 32'h1);
        check("dir_out_data", out_data, 32'd3);
        check("dir_out_chan", 32'(out_chan), 32'd2);
        step();
        check("dir_drained", 32'(out_valid), 32'h0);
        check("idle_keep_data", out_data, 32'd3);

        // Reset mid-stream discards the held word (never pushed)
        out_ready = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        step();
        in_valid = '0;
        #1;
        check("held_valid", 32'(out_valid), 32'h1);
        check("held_data", out_data, 32'd2);
        rst_n    = 1'b0;
        in_valid = 4'hF;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        step();
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_data", out_data, 32'h0);
        in_valid = '0;
        rst_n    = 1'b1;

        // Round-robin fairness from reset: 0,1,2,3,0
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'h1);
        exp_q.push_back('{data: 32'd1, chan: 2'd0});
        exp_q.push_back('{data: 32'd2, chan: 2'd1});
        exp_q.push_back('{data: 32'd3, chan: 2'd2});
        exp_q.push_back('{data: 32'd4, chan: 2'd3});
        exp_q.push_back('{data: 32'd1, chan: 2'd0});
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_valid", 32'(out_valid), 32'h1);
            check("rr_chan", 32'(out_chan), 32'(i % 4));
        end
        in_valid = '0;
        step();
        check("rr_drained", 32'(out_valid), 32'h0);

        // Back-pressure: hold word 1 for 3 cycles, then accept channel 3
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        exp_q.push_back('{data: 32'd1, chan: 2'd0});
        step();
        sel      = 2'd3;
        in_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_hold_data", out_data, 32'd1);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h8);
        exp_q.push_back('{data: 32'd4, chan: 2'd3});
        step();
        in_valid = '0;
        #1;
        check("bp_nobubble_valid", 32'(out_valid), 32'h1);
        check("bp_nobubble_data", out_data, 32'd4);
        step();
        check("bp_drained", 32'(out_valid), 32'h0);

        // Skip and wrap: last = 3, requests on 1 and 3 -> 1,3,1
        mode     = 1'b1;
        in_valid = 4'b1010;
        #1;
        check("sw_first_ready", 32'(in_ready), 32'h2);
        exp_q.push_back('{data: 32'd2, chan: 2'd1});
        exp_q.push_back('{data: 32'd4, chan: 2'd3});
        exp_q.push_back('{data: 32'd2, chan: 2'd1});
        step();
        check("sw_chan0", 32'(out_chan), 32'd1);
        step();
        check("sw_chan1", 32'(out_chan), 32'd3);
        step();
        check("sw_chan2", 32'(out_chan), 32'd1);
        in_valid = '0;
        step();

        // Out-of-range select on the 3-channel instance
        mode3     = 1'b0;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        #1;
        check("oor_in_ready", 32'(in_ready3), 32'h0);
        step();
        check("oor_valid0", 32'(out_valid3), 32'h0);
        step();
        check("oor_valid1", 32'(out_valid3), 32'h0);
        sel3 = 2'd2;
        #1;
        check("n3_in_ready", 32'(in_ready3), 32'h4);
        step();
        in_valid3 = '0;
        check("n3_valid", 32'(out_valid3), 32'h1);
        check("n3_data", out_data3, 32'd30);
        check("n3_chan", 32'(out_chan3), 32'd2);

        // Bounded drain of anything still expected
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_n_reg.md
MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 SHALL have parameter W, default 32: data width per channel.
REQ-002 SHALL have parameter N, default 4: number of input channels, range 2..16.
REQ-003 SHALL have derived localparam SW = max(1, clog2(N)): the channel-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port in_data, input, N*W bits: channel i occupies bits [i*W +: W].
REQ-007 SHALL have port in_valid, input, N bits: per-channel data valid.
REQ-008 SHALL have port in_ready, output, N bits: per-channel accept.
REQ-009 SHALL have port mode, input, 1 bit: 0 = direct select, 1 = round-robin.
REQ-010 SHALL have port sel, input, SW bits: channel index used in direct mode.
REQ-011 SHALL have port out_data, output, W bits: registered selected data.
REQ-012 SHALL have port out_chan, output, SW bits: index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid, output, 1 bit: output register holds data.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts data.

Function
REQ-015 SHALL define transfer on input channel i as in_valid[i] & in_ready[i] at a rising edge, and output transfer as out_valid & out_ready at a rising edge.
REQ-016 SHALL define load_ok = !out_valid | out_ready. The output register may load only when load_ok = 1.
REQ-017 SHALL grant in direct mode the channel sel, only when in_valid[sel] = 1 and sel < N. If sel >= N, no channel is granted.
REQ-018 SHALL grant in round-robin mode the first channel with in_valid set, searching from (last + 1) mod N upward with wrap-around. last is the most recently granted channel.
REQ-019 SHALL drive in_ready[i] = load_ok & (grant == i) & grant_valid. At most one in_ready bit is high at a time, and in_ready is combinational from in_valid, mode, sel, out_valid and out_ready.
REQ-020 SHALL, on an input transfer, load out_data, out_chan and out_valid = 1 at the same edge. Latency is one cycle from in_valid to out_valid.
REQ-021 SHALL clear out_valid on an output transfer with no simultaneous input transfer.
REQ-022 SHALL, when an output transfer and an input transfer occur at the same edge, replace the output register with the new data. This gives full throughput of one word per cycle.
REQ-023 SHALL hold out_data and out_chan stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL update last only on an input transfer, in either mode. Direct-mode grants therefore move the round-robin pointer.
REQ-025 SHALL apply a change to mode or sel at the next grant evaluation; data already held in the output register is unaffected.
REQ-026 SHALL keep out_data and out_chan at their last values when out_valid = 0.

Reset
REQ-027 SHALL, when rst_n = 0 at a rising edge, set out_valid = 0, out_data = 0, out_chan = 0 and last = N-1, so that channel 0 has first round-robin priority.
REQ-028 SHALL hold all in_ready bits at 0 in every cycle in which rst_n = 0.
REQ-029 SHALL discard any data held at reset (no flush or completion). Reset asserted mid-stream loses the held word.

Structure
REQ-030 SHALL place the default W and N constants, and the mode encoding constants MODE_DIRECT = 0 and MODE_RR = 1, in shared package mux_pkg.
REQ-031 SHALL implement round-robin grant selection as sub-module rr_arb. Its ports are req[N], last[SW] in, and grant[SW], grant_valid out. rr_arb is purely combinational.
REQ-032 SHALL contain exactly one register stage on the data path, and no storage beyond the output register and last.

Verification
REQ-033 SHALL cover direct select: W=32, N=4, mode=0, sel=2, in_data channel 2 = 32'd3, in_valid = 4'b0100, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 3, out_chan = 2, out_valid = 1.
REQ-034 SHALL cover round-robin fairness: mode=1, in_valid = 4'b1111 held, channel values 1,2,3,4, out_ready = 1 -> out_chan sequence 0,1,2,3,0 and out_data 1,2,3,4,1 on consecutive cycles.
REQ-035 SHALL cover back-pressure: out_valid = 1 with out_data = 1, out_ready = 0 for 3 cycles -> in_ready = 0 and out_data stays 1. Then out_ready = 1 with a pending channel -> new data the next cycle with no bubble.
REQ-036 SHALL cover skip and wrap: mode=1, last = 3, in_valid = 4'b1010 -> grant channel 1, then channel 3, then channel 1.
REQ-037 SHALL cover out-of-range select: N=3, mode=0, sel=3, in_valid = 3'b111 -> in_ready = 0 and out_valid stays 0.
REQ-038 SHALL cover reset mid-stream: rst_n = 0 for one cycle while out_valid = 1 -> the next cycle shows out_valid = 0 and out_data = 0. The first round-robin grant after reset is channel 0.
